// File: rtl/bbox_msg_reader_if.sv
// Bus bundle for bbox_msg_reader: the Avalon-MM master signals toward the
// image processor's message port, plus the decoded-box valid/ready output.
interface bbox_msg_reader_if;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  logic        bb_valid;
  logic        bb_ready;
  logic [10:0] bb_x_min;
  logic [10:0] bb_y_min;
  logic [10:0] bb_x_max;
  logic [10:0] bb_y_max;
  logic        bb_found;

  // Reader side: drives the bus strobes and presents boxes.
  modport master (
    output m_chipselect, m_read, m_write, m_address, m_writedata,
    input  m_readdata,
    output bb_valid, bb_x_min, bb_y_min, bb_x_max, bb_y_max, bb_found,
    input  bb_ready
  );

  // Slave/consumer side: answers reads and accepts boxes.
  modport slave (
    input  m_chipselect, m_read, m_write, m_address, m_writedata,
    output m_readdata,
    input  bb_valid, bb_x_min, bb_y_min, bb_x_max, bb_y_max, bb_found,
    output bb_ready
  );
endinterface

// File: rtl/bbox_msg_reader.sv
// bbox_msg_reader: polls the image processor's status register, pops message
// words one at a time, frames the three-word red-box message (ID, top-left,
// bottom-right) and presents each decoded box on a valid/ready output.
module bbox_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter logic [31:0] MSG_ID        = 32'h0052_4242
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               flush_req,
  bbox_msg_reader_if.master  bus,
  output logic [15:0]        msg_count,
  output logic [7:0]         err_count
);

  typedef enum logic [2:0] {
    POLL, ST_REQ, ST_CAP, MSG_REQ, MSG_CAP, OUT, FLUSH
  } state_t;

  localparam logic [15:0] TIMER_LOAD = 16'(POLL_INTERVAL - 1);

  state_t      state;
  logic [15:0] timer;
  logic [7:0]  avail;
  logic [1:0]  idx;
  logic        flush_pend;

  // Top-left corner staged while the frame is incomplete.
  logic [10:0] x_min_s, y_min_s;

  // Presented box; only updated when a complete frame is decoded.
  logic [10:0] x_min_q, y_min_q, x_max_q, y_max_q;
  logic        found_q;

  logic [31:0] w;
  logic        w_is_id;
  logic        w_bad;
  logic        box_done;
  logic [7:0]  err_inc;

  assign w        = bus.m_readdata;
  assign w_is_id  = (w == MSG_ID);
  // Coordinates are 11 bits; any set bit above them marks a corrupt word.
  assign w_bad    = (w[31:27] != 5'd0) || (w[15:11] != 5'd0);
  assign box_done = (idx == 2'd2) && !w_is_id && !w_bad;
  assign err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  // Bus strobes decoded from state alone, so each is a single-cycle pulse.
  assign bus.m_chipselect = (state == ST_REQ) || (state == MSG_REQ) || (state == FLUSH);
  assign bus.m_read       = (state == ST_REQ) || (state == MSG_REQ);
  assign bus.m_write      = (state == FLUSH);
  assign bus.m_address    = (state == MSG_REQ) ? 3'd1 : 3'd0;
  assign bus.m_writedata  = (state == FLUSH) ? 32'h0000_0010 : 32'h0;
  assign bus.bb_valid     = (state == OUT);
  assign bus.bb_x_min     = x_min_q;
  assign bus.bb_y_min     = y_min_q;
  assign bus.bb_x_max     = x_max_q;
  assign bus.bb_y_max     = y_max_q;
  assign bus.bb_found     = found_q;

  // Poll / pop / frame state machine with its counters and box registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= POLL;
      timer      <= 16'd0;
      avail      <= 8'd0;
      idx        <= 2'd0;
      flush_pend <= 1'b0;
      x_min_s    <= '0;
      y_min_s    <= '0;
      x_min_q    <= '0;
      y_min_q    <= '0;
      x_max_q    <= '0;
      y_max_q    <= '0;
      found_q    <= 1'b0;
      msg_count  <= 16'd0;
      err_count  <= 8'd0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the pre-edge
      // avail/idx/flush_pend, and the FLUSH clear wins over a same-cycle set.
      if (flush_req) flush_pend <= 1'b1;

      unique case (state)
        POLL: begin
          if (flush_pend) begin
            state <= FLUSH;
          end else if (timer == 16'd0) begin
            if (enable) state <= ST_REQ;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        ST_REQ: state <= ST_CAP;

        ST_CAP: begin
          avail <= w[15:8];
          if (w[15:8] == 8'd0) begin
            state <= POLL;
            timer <= TIMER_LOAD;
          end else begin
            state <= MSG_REQ;
          end
        end

        MSG_REQ: begin
          avail <= avail - 8'd1;
          state <= MSG_CAP;
        end

        MSG_CAP: begin
          unique case (idx)
            2'd0: begin
              if (w_is_id) idx <= 2'd1;
              else         err_count <= err_inc;
            end
            2'd1: begin
              if (w_is_id) begin
                err_count <= err_inc;
              end else if (w_bad) begin
                err_count <= err_inc;
                idx       <= 2'd0;
              end else begin
                x_min_s <= w[26:16];
                y_min_s <= w[10:0];
                idx     <= 2'd2;
              end
            end
            default: begin
              if (w_is_id) begin
                err_count <= err_inc;
                idx       <= 2'd1;
              end else if (w_bad) begin
                err_count <= err_inc;
                idx       <= 2'd0;
              end else begin
                x_min_q <= x_min_s;
                y_min_q <= y_min_s;
                x_max_q <= w[26:16];
                y_max_q <= w[10:0];
                found_q <= (x_min_s <= w[26:16]);
                idx     <= 2'd0;
              end
            end
          endcase
          // A partial frame re-polls status immediately instead of idling.
          if (box_done)            state <= OUT;
          else if (avail != 8'd0)  state <= MSG_REQ;
          else                     state <= ST_REQ;
        end

        OUT: begin
          if (bus.bb_ready) begin
            msg_count <= msg_count + 16'd1;
            if (avail != 8'd0) begin
              state <= MSG_REQ;
            end else begin
              state <= POLL;
              timer <= TIMER_LOAD;
            end
          end
        end

        FLUSH: begin
          flush_pend <= 1'b0;
          idx        <= 2'd0;
          avail      <= 8'd0;
          state      <= POLL;
          timer      <= TIMER_LOAD;
        end

        default: state <= POLL;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_msg_reader.sv
// Testbench for bbox_msg_reader: behavioural message-port slave, expected-box
// scoreboard, and one task per scenario.
module tb_bbox_msg_reader;

  localparam logic [31:0] ID = 32'h0052_4242;

  typedef struct {
    logic [10:0] x0, y0, x1, y1;
    logic        found;
  } box_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush_req = 1'b0;
  logic [15:0] msg_count;
  logic [7:0]  err_count;

  bbox_msg_reader_if bus ();

  bbox_msg_reader #(.POLL_INTERVAL(16), .MSG_ID(ID)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .flush_req (flush_req),
    .bus       (bus),
    .msg_count (msg_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Slave model state.
  logic [31:0] fifo[$];
  int          poll_limit = 255;
  int          st_log[$];
  int          msg_reads = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  logic [2:0]  last_waddr;
  logic [31:0] last_wdata;
  bit          prev_bus = 0;
  int          sl_n;
  logic [7:0]  sl_av;

  box_t exp_q[$];
  box_t mon_e;

  always @(posedge clk) cyc++;

  // Message-port slave: answers at the negedge of the read cycle, so the data
  // is stable at the following edge where the reader samples it.
  always @(negedge clk) begin
    if (bus.m_read || bus.m_write) begin
      n_checks++;
      if (bus.m_read && bus.m_write) begin
        n_fail++;
        $display("FAIL bus_overlap cyc=%0d read=%b write=%b required not both", cyc, bus.m_read, bus.m_write);
      end
      n_checks++;
      if (prev_bus) begin
        n_fail++;
        $display("FAIL bus_consecutive cyc=%0d strobe in two consecutive cycles", cyc);
      end
      n_checks++;
      if (bus.m_chipselect !== 1'b1) begin
        n_fail++;
        $display("FAIL bus_chipselect cyc=%0d got=%b required=1", cyc, bus.m_chipselect);
      end
    end
    prev_bus = bus.m_read || bus.m_write;

    if (bus.m_read) begin
      n_reads++;
      if (bus.m_address == 3'd0) begin
        st_log.push_back(cyc);
        sl_n = fifo.size();
        if (sl_n > poll_limit) sl_n = poll_limit;
        if (sl_n > 255) sl_n = 255;
        sl_av = 8'(sl_n);
        bus.m_readdata = {16'h0, sl_av, 8'h0};
      end else begin
        msg_reads++;
        bus.m_readdata = (fifo.size() != 0) ? fifo.pop_front() : 32'h0;
      end
    end
    if (bus.m_write) begin
      n_writes++;
      last_waddr = bus.m_address;
      last_wdata = bus.m_writedata;
      fifo.delete();
    end
  end

  // Scoreboard: each accepted box must match the oldest expected box.
  always @(negedge clk) begin
    if (reset_n && bus.bb_valid && bus.bb_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL box_unexpected got=(%0d,%0d,%0d,%0d,%b) required none",
                 bus.bb_x_min, bus.bb_y_min, bus.bb_x_max, bus.bb_y_max, bus.bb_found);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.bb_x_min, bus.bb_y_min, bus.bb_x_max, bus.bb_y_max, bus.bb_found} !==
            {mon_e.x0, mon_e.y0, mon_e.x1, mon_e.y1, mon_e.found}) begin
          n_fail++;
          $display("FAIL box_value got=(%0d,%0d,%0d,%0d,%b) required=(%0d,%0d,%0d,%0d,%b)",
                   bus.bb_x_min, bus.bb_y_min, bus.bb_x_max, bus.bb_y_max, bus.bb_found,
                   mon_e.x0, mon_e.y0, mon_e.x1, mon_e.y1, mon_e.found);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    fifo.delete();
    exp_q.delete();
    st_log.delete();
    msg_reads  = 0;
    n_reads    = 0;
    n_writes   = 0;
    poll_limit = 255;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    flush_req = 1'b0;
    enable    = 1'b1;
    clear_model();
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic push_msg(input logic [10:0] x0, input logic [10:0] y0,
                          input logic [10:0] x1, input logic [10:0] y1);
    box_t b;
    fifo.push_back(ID);
    fifo.push_back({5'd0, x0, 5'd0, y0});
    fifo.push_back({5'd0, x1, 5'd0, y1});
    b.x0 = x0; b.y0 = y0; b.x1 = x1; b.y1 = y1;
    b.found = (x0 <= x1);
    exp_q.push_back(b);
  endtask

  task automatic wait_msgs(input int target, input int budget, input string tag);
    int t = 0;
    while (msg_count != 16'(target) && t < budget) begin
      step();
      t++;
    end
    n_checks++;
    if (msg_count !== 16'(target)) begin
      n_fail++;
      $display("FAIL %s_msg_count got=%0d required=%0d", tag, msg_count, target);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    bus.bb_ready = 1'b0;
    clear_model();
    step(2);
    n_checks++;
    if ({bus.m_chipselect, bus.m_read, bus.m_write, bus.m_address, bus.m_writedata,
         bus.bb_valid, bus.bb_x_min, bus.bb_y_min, bus.bb_x_max, bus.bb_y_max,
         bus.bb_found, msg_count, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got cs=%b rd=%b wr=%b valid=%b found=%b msg=%0d err=%0d required all 0",
               bus.m_chipselect, bus.m_read, bus.m_write, bus.bb_valid, bus.bb_found, msg_count, err_count);
    end
    reset_n = 1'b1;
    n_checks++;
    if (bus.m_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_cycle_read got=%b required=0", bus.m_read);
    end
    step();
    n_checks++;
    if ({bus.m_read, bus.m_chipselect, bus.m_address} !== {1'b1, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_second_cycle_status_read got rd=%b cs=%b addr=%0d required rd=1 cs=1 addr=0",
               bus.m_read, bus.m_chipselect, bus.m_address);
    end
  endtask

  task automatic test_single_box();
    int t, t0;
    do_reset();
    bus.bb_ready = 1'b1;
    push_msg(11'd100, 11'd50, 11'd200, 11'd150);
    t = 0;
    while (!(bus.m_read && bus.m_address == 3'd1) && t < 60) begin step(); t++; end
    t0 = cyc;
    t = 0;
    while (!bus.bb_valid && t < 30) begin step(); t++; end
    n_checks++;
    if (cyc - t0 != 6) begin
      n_fail++;
      $display("FAIL single_valid_latency got=%0d required=6", cyc - t0);
    end
    step(2);
    n_checks++;
    if (msg_count !== 16'd1 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL single_counts got msg=%0d err=%0d required msg=1 err=0", msg_count, err_count);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_box_missing got pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int t, reads0;
    do_reset();
    bus.bb_ready = 1'b0;
    push_msg(11'd100, 11'd50, 11'd200, 11'd150);
    t = 0;
    while (!bus.bb_valid && t < 60) begin step(); t++; end
    reads0 = n_reads;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({bus.bb_valid, bus.bb_x_min, bus.bb_y_min, bus.bb_x_max, bus.bb_y_max, bus.bb_found} !==
          {1'b1, 11'd100, 11'd50, 11'd200, 11'd150, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold cycle=%0d got valid=%b box=(%0d,%0d,%0d,%0d,%b) required valid=1 box=(100,50,200,150,1)",
                 i, bus.bb_valid, bus.bb_x_min, bus.bb_y_min, bus.bb_x_max, bus.bb_y_max, bus.bb_found);
      end
      step();
    end
    n_checks++;
    if (n_reads != reads0 || msg_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_no_reads got extra_reads=%0d msg=%0d required 0 and 0", n_reads - reads0, msg_count);
    end
    bus.bb_ready = 1'b1;
    step();
    bus.bb_ready = 1'b0;
    n_checks++;
    if (msg_count !== 16'd1 || bus.bb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_accept got msg=%0d valid=%b required msg=1 valid=0", msg_count, bus.bb_valid);
    end
    step(5);
    n_checks++;
    if (msg_count !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_single_increment got=%0d required=1", msg_count);
    end
  endtask

  task automatic test_error_resync();
    box_t b;
    do_reset();
    bus.bb_ready = 1'b1;
    fifo.push_back(32'hDEAD_BEEF);
    fifo.push_back(ID);
    fifo.push_back(32'h027F_01DF);
    fifo.push_back(32'h0000_0000);
    b.x0 = 11'd639; b.y0 = 11'd479; b.x1 = 11'd0; b.y1 = 11'd0; b.found = 1'b0;
    exp_q.push_back(b);
    wait_msgs(1, 200, "resync");
    step(2);
    n_checks++;
    if (err_count !== 8'd1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL resync_err got err=%0d pending=%0d required err=1 pending=0", err_count, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.bb_ready = 1'b1;
    poll_limit = 1;
    push_msg(11'd10, 11'd20, 11'd30, 11'd40);
    push_msg(11'd5, 11'd6, 11'd7, 11'd8);
    wait_msgs(2, 400, "b2b");
    step(2);
    n_checks++;
    if (err_count !== 8'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_clean got err=%0d pending=%0d required 0 and 0", err_count, exp_q.size());
    end
    n_checks++;
    if (st_log.size() < 6) begin
      n_fail++;
      $display("FAIL b2b_status_reads got=%0d required>=6", st_log.size());
    end else if (st_log[1] - st_log[0] != 4 || st_log[2] - st_log[1] != 4 ||
                 st_log[3] - st_log[2] != 21 ||
                 st_log[4] - st_log[3] != 4 || st_log[5] - st_log[4] != 4) begin
      n_fail++;
      $display("FAIL b2b_status_spacing got=%0d,%0d,%0d,%0d,%0d required=4,4,21,4,4",
               st_log[1] - st_log[0], st_log[2] - st_log[1], st_log[3] - st_log[2],
               st_log[4] - st_log[3], st_log[5] - st_log[4]);
    end
  endtask

  task automatic test_empty_poll();
    int t;
    do_reset();
    bus.bb_ready = 1'b1;
    t = 0;
    while (st_log.size() < 3 && t < 100) begin step(); t++; end
    n_checks++;
    if (st_log.size() < 3) begin
      n_fail++;
      $display("FAIL empty_status_reads got=%0d required>=3", st_log.size());
    end else if (st_log[1] - st_log[0] != 18 || st_log[2] - st_log[1] != 18) begin
      n_fail++;
      $display("FAIL empty_spacing got=%0d,%0d required=18,18",
               st_log[1] - st_log[0], st_log[2] - st_log[1]);
    end
    n_checks++;
    if (msg_reads != 0) begin
      n_fail++;
      $display("FAIL empty_msg_reads got=%0d required=0", msg_reads);
    end
  endtask

  task automatic test_flush();
    int t;
    do_reset();
    bus.bb_ready = 1'b1;
    fifo.push_back(ID);
    fifo.push_back(32'h0064_0032);
    t = 0;
    while (!(bus.m_read && bus.m_address == 3'd1 && msg_reads == 1) && t < 60) begin step(); t++; end
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    t = 0;
    while (n_writes == 0 && t < 60) begin step(); t++; end
    step(40);
    n_checks++;
    if (n_writes != 1 || last_waddr !== 3'd0 || last_wdata !== 32'h10) begin
      n_fail++;
      $display("FAIL flush_write got writes=%0d addr=%0d data=%h required 1, 0, 00000010",
               n_writes, last_waddr, last_wdata);
    end
    // Two well-formed stale words: with the frame index cleared they are
    // both errors; a surviving index would turn them into a bogus box.
    fifo.push_back(32'h00C8_0096);
    fifo.push_back(32'h00C8_0096);
    push_msg(11'd1, 11'd2, 11'd3, 11'd4);
    wait_msgs(1, 300, "flush");
    step(2);
    n_checks++;
    if (err_count !== 8'd2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_idx_reset got err=%0d pending=%0d required err=2 pending=0", err_count, exp_q.size());
    end
  endtask

  initial begin
    bus.bb_ready   = 1'b0;
    bus.m_readdata = 32'h0;
    test_reset();
    test_single_box();
    test_backpressure();
    test_error_resync();
    test_back_to_back();
    test_empty_poll();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
